product_arbiter: RTL and testbench

// - Shares one `product` multiplier lane-array between NUM_REQ requesters in the SpMV datapath.
// - Round-robin grant, at most one issue per cycle, into a fixed-latency (DELAY) pipeline that cannot stall.
// - Tags each issue with its requester id, then buffers products in an output FIFO that is protected by credits.
// - Drives results out on one valid/ready port, with the id attached.

---
 rtl/product_arbiter_pkg.sv | 24 ++
 rtl/product_arbiter_fifo.sv | 58 +++++
 rtl/product_arbiter.sv | 160 ++++++++++++++++
 tb/tb_product_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/product_arbiter_pkg.sv
// rtl/product_arbiter_pkg.sv - shared types and sizing helpers for product_arbiter
package product_arbiter_pkg;

    localparam int PA_NUM_REQ    = 4;
    localparam int PA_FIFO_DEPTH = 4;
    localparam int ID_W          = $clog2(PA_NUM_REQ);
    localparam int CREDIT_W      = $clog2(PA_FIFO_DEPTH + 1);

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        logic valid;
        id_t  id;
    } tag_t;

    function automatic int out_width(input int float_en, input int data_width);
        return (float_en != 0) ? data_width : 2 * data_width;
    endfunction

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/product_arbiter_fifo.sv
// rtl/product_arbiter_fifo.sv - synchronous result FIFO, no fall-through (push visible next cycle)
module product_arbiter_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_count == CNTW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop & ~o_empty;
    assign o_pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNTW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/product_arbiter.sv
// rtl/product_arbiter.sv - round-robin share of one product lane array, credit-protected result FIFO
// Optional grant/stall counters under PRODUCT_ARBITER_STATS_EN.
module product_arbiter
    import product_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = PA_NUM_REQ,
    parameter int FLOAT       = 1,
    parameter int DATA_WIDTH  = 32,
    parameter int PARALLELISM = 4,
    parameter int DELAY       = 2,
    parameter int FIFO_DEPTH  = PA_FIFO_DEPTH,
    localparam int OW         = out_width(FLOAT, DATA_WIDTH),
    localparam int BEAT_W     = PARALLELISM * DATA_WIDTH,
    localparam int RES_W      = PARALLELISM * OW
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*BEAT_W-1:0]   req_a,
    input  logic [NUM_REQ*BEAT_W-1:0]   req_b,
    output logic                        prod_valid,
    output logic [BEAT_W-1:0]           prod_a,
    output logic [BEAT_W-1:0]           prod_b,
    output logic                        prod_ready,
    input  logic [RES_W-1:0]            prod_res,
    input  logic                        prod_res_valid,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [RES_W-1:0]            res_data,
    output logic [$clog2(NUM_REQ)-1:0]  res_id,
    output logic                        tag_err
`ifdef PRODUCT_ARBITER_STATS_EN
    ,
    output logic [31:0]                 grant_cnt [NUM_REQ],
    output logic [31:0]                 stall_cnt
`endif
);

    localparam int CW = credit_width(FIFO_DEPTH);
    localparam int FW = RES_W + ID_W;

    logic [CW-1:0]  r_credits;
    id_t            r_rr_ptr;
    tag_t           r_tag [DELAY];
    logic           r_tag_err;

    logic           w_any;
    logic           w_issue;
    logic           w_pop;
    logic           w_push;
    logic           w_full;
    logic           w_empty;
    id_t            w_grant;
    id_t            w_idx;
    logic [FW-1:0]  w_fifo_out;

    // Scan from farthest to nearest so the first valid at/after rr_ptr wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = r_rr_ptr;
        w_idx   = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = id_t'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    // rst_n gates the grant so nothing is accepted while reset is held.
    assign w_issue = rst_n & w_any & (r_credits != '0);

    always_comb begin
        req_ready = '0;
        if (w_issue) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign prod_valid = w_issue;
    assign prod_a     = req_a[w_grant * BEAT_W +: BEAT_W];
    assign prod_b     = req_b[w_grant * BEAT_W +: BEAT_W];
    assign prod_ready = 1'b1;

    assign res_valid  = ~w_empty;
    assign w_pop      = res_valid & res_ready;
    assign w_push     = prod_res_valid & r_tag[DELAY-1].valid & ~w_full;
    assign res_data   = w_fifo_out[FW-1:ID_W];
    assign res_id     = w_fifo_out[ID_W-1:0];
    assign tag_err    = r_tag_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= CW'(FIFO_DEPTH);
            r_rr_ptr  <= '0;
            r_tag_err <= 1'b0;
            for (int s = 0; s < DELAY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            if (w_issue && !w_pop) begin
                r_credits <= r_credits - CW'(1);
            end else if (!w_issue && w_pop) begin
                r_credits <= r_credits + CW'(1);
            end
            if (w_issue) begin
                r_rr_ptr <= (w_grant == id_t'(NUM_REQ - 1)) ? '0 : w_grant + id_t'(1);
            end
            r_tag[0].valid <= w_issue;
            r_tag[0].id    <= w_grant;
            for (int s = 1; s < DELAY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
            if (prod_res_valid != r_tag[DELAY-1].valid) begin
                r_tag_err <= 1'b1;
            end
        end
    end

    product_arbiter_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data ({prod_res, r_tag[DELAY-1].id}),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_out),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

`ifdef PRODUCT_ARBITER_STATS_EN
    logic [31:0] r_grant_cnt [NUM_REQ];
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                r_grant_cnt[r] <= '0;
            end
            r_stall_cnt <= '0;
        end else begin
            if (w_issue && (r_grant_cnt[w_grant] != '1)) begin
                r_grant_cnt[w_grant] <= r_grant_cnt[w_grant] + 32'd1;
            end
            if (w_any && (r_credits == '0) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_product_arbiter.sv
// tb/tb_product_arbiter.sv - directed self-checking bench for product_arbiter
module tb_product_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int PAR     = 4;
    localparam int DELAY   = 2;
    localparam int DEPTH   = 4;
    localparam int OW      = 32;
    localparam int BEAT_W  = PAR * DW;
    localparam int RES_W   = PAR * OW;

    localparam logic [31:0] F1 = 32'h3F800000;
    localparam logic [31:0] F2 = 32'h40000000;
    localparam logic [31:0] F3 = 32'h40400000;
    localparam logic [31:0] F4 = 32'h40800000;
    localparam logic [31:0] F6 = 32'h40C00000;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*BEAT_W-1:0] req_a;
    logic [NUM_REQ*BEAT_W-1:0] req_b;
    logic                      prod_valid;
    logic [BEAT_W-1:0]         prod_a;
    logic [BEAT_W-1:0]         prod_b;
    logic                      prod_ready;
    logic [RES_W-1:0]          prod_res;
    logic                      prod_res_valid;
    logic                      res_valid;
    logic                      res_ready;
    logic [RES_W-1:0]          res_data;
    logic [1:0]                res_id;
    logic                      tag_err;
`ifdef PRODUCT_ARBITER_STATS_EN
    logic [31:0]               grant_cnt [NUM_REQ];
    logic [31:0]               stall_cnt;
`endif

    int          total = 0;
    int          bad = 0;
    int          n_issue;
    int          n_pop;
    logic        inj = 1'b0;
    logic [31:0] vals [NUM_REQ];

    logic [DELAY-1:0] pm_v;
    logic [RES_W-1:0] pm_d [DELAY];

    always #5 clk = ~clk;

    product_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .FLOAT       (1),
        .DATA_WIDTH  (DW),
        .PARALLELISM (PAR),
        .DELAY       (DELAY),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .prod_valid     (prod_valid),
        .prod_a         (prod_a),
        .prod_b         (prod_b),
        .prod_ready     (prod_ready),
        .prod_res       (prod_res),
        .prod_res_valid (prod_res_valid),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_id         (res_id),
        .tag_err        (tag_err)
`ifdef PRODUCT_ARBITER_STATS_EN
        ,
        .grant_cnt      (grant_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        if (b == F1) return a;
        if (a == F1) return b;
        if (a == F2 && b == F3) return F6;
        return 32'hDEADBEEF;
    endfunction

    function automatic logic [BEAT_W-1:0] bcast(input logic [31:0] v);
        return {PAR{v}};
    endfunction

    // Stand-in for the fixed-latency multiplier lane array.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_v <= '0;
            for (int s = 0; s < DELAY; s++) pm_d[s] <= '0;
        end else begin
            pm_v <= {pm_v[DELAY-2:0], prod_valid};
            for (int l = 0; l < PAR; l++)
                pm_d[0][l*OW +: OW] <= fmul(prod_a[l*DW +: DW], prod_b[l*DW +: DW]);
            for (int s = 1; s < DELAY; s++) pm_d[s] <= pm_d[s-1];
        end
    end

    assign prod_res_valid = pm_v[DELAY-1] | inj;
    assign prod_res       = pm_d[DELAY-1];

    task automatic chk(input string tag, input logic [RES_W-1:0] obs, input logic [RES_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        vals[0] = F1; vals[1] = F2; vals[2] = F3; vals[3] = F4;

        // reset state, with requesters already asserting valid
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_prod_valid", prod_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_tag_err", tag_err, 0);
        req_valid = '0;
        next_cycle();
        rst_n = 1'b1;

        // single requester, 2.0 * 3.0 on every lane
        req_a[BEAT_W-1:0] = bcast(F2);
        req_b[BEAT_W-1:0] = bcast(F3);
        req_valid = 4'b0001;
        res_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("s1_ready", req_ready, 4'b0001);
            if (i == 0) begin
                chk("s1_prod_valid", prod_valid, 1);
                chk("s1_prod_a", prod_a, bcast(F2));
                chk("s1_prod_b", prod_b, bcast(F3));
            end
            if (i < 3) chk("s1_latency", res_valid, 0);
            if (i >= 3) begin
                chk("s1_res_valid", res_valid, 1);
                chk("s1_res_data", res_data, bcast(F6));
                chk("s1_res_id", res_id, 0);
            end
            next_cycle();
        end
        req_valid = '0;
        repeat (4) next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;

        // all four requesters, round-robin with no bubbles
        for (int k = 0; k < NUM_REQ; k++) begin
            req_a[k*BEAT_W +: BEAT_W] = bcast(vals[k]);
            req_b[k*BEAT_W +: BEAT_W] = bcast(F1);
        end
        req_valid = 4'hF;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) req_valid = '0;
            @(negedge clk);
            if (i < 8) chk("s2_grant", req_ready, 4'b0001 << (i % 4));
            if (i >= 3 && i < 11) begin
                chk("s2_res_valid", res_valid, 1);
                chk("s2_res_id", res_id, (i - 3) % 4);
                chk("s2_res_data", res_data, bcast(vals[(i - 3) % 4]));
            end
            next_cycle();
        end

        // back-pressure: credits run out after FIFO_DEPTH issues
        res_ready = 1'b0;
        req_valid = 4'hF;
        n_issue = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready != '0) n_issue++;
            if (i < 4) chk("s3_grant", req_ready, 4'b0001 << i);
            next_cycle();
        end
        chk("s3_issue_count", n_issue, DEPTH);
        @(negedge clk);
        chk("s3_stalled", req_ready, 0);
        chk("s3_held_valid", res_valid, 1);
        chk("s3_held_id", res_id, 0);
        chk("s3_held_data", res_data, bcast(vals[0]));
        next_cycle();

        // release: one issue per pop, pop+issue with one credit keeps flowing
        res_ready = 1'b1;
        n_issue = 0;
        n_pop = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 6) req_valid = '0;
            @(negedge clk);
            if (req_ready != '0) n_issue++;
            if (i == 0) chk("s3_zero_credit", req_ready, 0);
            if (i == 1 || i == 2) chk("s3_pop_and_issue", prod_valid, 1);
            if (res_valid) begin
                chk("s3_pop_id", res_id, n_pop % 4);
                chk("s3_pop_data", res_data, bcast(vals[n_pop % 4]));
                n_pop++;
            end
            next_cycle();
        end
        chk("s3_release_issues", n_issue, 5);
        chk("s3_pop_total", n_pop, 9);

        // returned valid with no tag in flight
        @(negedge clk);
        chk("s4_tag_err_clear", tag_err, 0);
        next_cycle();
        inj = 1'b1;
        @(negedge clk);
        chk("s4_tag_err_not_yet", tag_err, 0);
        next_cycle();
        inj = 1'b0;
        @(negedge clk);
        chk("s4_tag_err_set", tag_err, 1);
        chk("s4_no_push", res_valid, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("s4_tag_err_sticky", tag_err, 1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk("s4_tag_err_reset", tag_err, 0);
        next_cycle();
        rst_n = 1'b1;

        // reset with beats in flight
        res_ready = 1'b0;
        req_valid = 4'hF;
        repeat (3) next_cycle();
        #1;
        chk("s5_pre_res_valid", res_valid, 1);
        chk("s5_pre_grant", req_ready, 4'b1000);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_res_valid", res_valid, 0);
        chk("s5_rst_req_ready", req_ready, 0);
        chk("s5_rst_prod_valid", prod_valid, 0);
        next_cycle();
        rst_n = 1'b1;
        n_issue = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) chk("s5_rr_ptr_reset", req_ready, 4'b0001);
            if (i == 3) chk("s5_no_stale_result", res_valid, (i >= 3) ? 1 : 0);
            if (req_ready != '0) n_issue++;
            next_cycle();
        end
        chk("s5_credits_reset", n_issue, DEPTH);
        chk("s5_tag_err", tag_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
